req_arbiter_8: RTL

- Sequential arbiter that shares one downstream resource among 8 requesters.
- Resolves simultaneous requests by priority, registers a one-hot grant plus its 3-bit index, and holds the grant while the winner keeps requesting.
- Forces re-arbitration after a bounded hold time so a long-running master cannot starve the others.
- Sits in front of any shared unit that today is selected by a plain 8-to-3 priority encode.

---
 rtl/req_arbiter_8.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/req_arbiter_8.sv
// 8-way request arbiter: registered one-hot grant with bounded hold time and preemption.
// Define REQ_ARB_ROUND_ROBIN_EN for rotating priority; otherwise req[7] has the highest fixed priority.
module req_arbiter_8 #(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] req,
   output logic [7:0] gnt,
   output logic [2:0] gnt_id,
   output logic       gnt_vld,
   output logic       preempt
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]       state_q,   state_d;
   logic [7:0]       gnt_q,     gnt_d;
   logic [2:0]       gnt_id_q,  gnt_id_d;
   logic             gnt_vld_q, gnt_vld_d;
   logic             preempt_q, preempt_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic [7:0]       mask_q,    mask_d;
   logic [7:0]       eff_req;
   logic [2:0]       win;
   logic             hold_full;
   logic             others_req;

   // The preempted requester is skipped once, unless it is the only one asking.
   always_comb begin
      eff_req = req & ~mask_q;
      if (eff_req == 8'h00) begin
         eff_req = req;
      end
   end

`ifdef REQ_ARB_ROUND_ROBIN_EN
   logic [2:0] ptr_q, ptr_d;
   logic [2:0] idx;

   // Rotating search from ptr upward; descending loop leaves the nearest hit.
   always_comb begin
      win = 3'd0;
      idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr_q + 3'(i);
         if (eff_req[idx]) begin
            win = idx;
         end
      end
   end
`else
   // Fixed priority: ascending loop leaves the highest set bit.
   always_comb begin
      win = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (eff_req[i]) begin
            win = 3'(i);
         end
      end
   end
`endif

   assign hold_full  = (cnt_q == CNT_W'(MAX_HOLD));
   assign others_req = ((req & ~gnt_q) != 8'h00);

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      preempt_d = 1'b0;
      cnt_d     = cnt_q;
      mask_d    = mask_q;
`ifdef REQ_ARB_ROUND_ROBIN_EN
      ptr_d     = ptr_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (en && (eff_req != 8'h00)) begin
               state_d   = ST_GRANT;
               gnt_d     = 8'h01 << win;
               gnt_id_d  = win;
               gnt_vld_d = 1'b1;
               cnt_d     = CNT_W'(1);
               mask_d    = 8'h00;
`ifdef REQ_ARB_ROUND_ROBIN_EN
               ptr_d     = win + 3'd1;
`endif
            end
         end
         default: begin
            if (!en || !req[gnt_id_q]) begin
               state_d   = ST_IDLE;
               gnt_d     = 8'h00;
               gnt_id_d  = 3'd0;
               gnt_vld_d = 1'b0;
               cnt_d     = '0;
            end else if (hold_full && others_req) begin
               state_d   = ST_IDLE;
               gnt_d     = 8'h00;
               gnt_id_d  = 3'd0;
               gnt_vld_d = 1'b0;
               cnt_d     = '0;
               preempt_d = 1'b1;
               mask_d    = gnt_q;
            end else if (!hold_full) begin
               cnt_d     = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         gnt_q     <= 8'h00;
         gnt_id_q  <= 3'd0;
         gnt_vld_q <= 1'b0;
         preempt_q <= 1'b0;
         cnt_q     <= '0;
         mask_q    <= 8'h00;
`ifdef REQ_ARB_ROUND_ROBIN_EN
         ptr_q     <= 3'd0;
`endif
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
         preempt_q <= preempt_d;
         cnt_q     <= cnt_d;
         mask_q    <= mask_d;
`ifdef REQ_ARB_ROUND_ROBIN_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;
   assign preempt = preempt_q;

endmodule
